// File: rtl/load_store_unit_if.sv
// Bundle of the core-side request/response handshake and the word-wide
// DataMemory port of the load/store unit.
// master: the load/store unit. slave: the core plus DataMemory.
interface load_store_unit_if;
  // Core request
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddress;
  logic [31:0] reqData;
  // Core response
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic        respError;
  // DataMemory port
  logic [31:0] memAddress;
  logic        memWriteEnabled;
  logic [31:0] memWriteInput;
  logic [31:0] memReadResult;

  modport master (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
    output reqReady,
    output respValid, respData, respError,
    input  respReady,
    output memAddress, memWriteEnabled, memWriteInput,
    input  memReadResult
  );

  modport slave (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
    input  reqReady,
    input  respValid, respData, respError,
    output respReady,
    input  memAddress, memWriteEnabled, memWriteInput,
    output memReadResult
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes byte/halfword/word requests from the core and runs
// them against a word-wide DataMemory port. Sub-word stores are performed as
// a read-modify-write of the containing word. Misaligned, illegal-size and
// out-of-range requests are answered with an error and never touch memory.
module load_store_unit #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Request captured at acceptance, plus its error classification.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } req_t;

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [33:0] SPAN      = 34'(MEM_WORDS) << 2;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] rd_word_q, rd_word_d;

  logic [33:0] byte_off;
  logic        req_err;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Classify the incoming request: alignment, size code and address window.
  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    req_err  = 1'b0;
    // Widened subtraction: a borrow into bit 33 means the address is below
    // BASE_ADDRESS, otherwise the offset is compared against the window size.
    byte_off = {2'b00, bus.reqAddress} - {2'b00, BASE_ADDRESS};
    case (bus.reqSize)
      SIZE_HALF: if (bus.reqAddress[0])          req_err = 1'b1;
      SIZE_WORD: if (bus.reqAddress[1:0] != 2'b00) req_err = 1'b1;
      SIZE_BYTE: ;
      default:   req_err = 1'b1;
    endcase
    if (byte_off[33] || (byte_off >= SPAN)) req_err = 1'b1;
  end

  // Store data: drop the right-aligned operand into its lane of the word read
  // back; a word store writes the operand as is.
  always_comb begin
    merged_word = rd_word_q;
    case (req_q.size)
      SIZE_BYTE: merged_word[{req_q.addr[1:0], 3'b000} +: 8]  = req_q.data[7:0];
      SIZE_HALF: merged_word[{req_q.addr[1], 4'b0000} +: 16]  = req_q.data[15:0];
      default:   merged_word = req_q.data;
    endcase
  end

  // Load data: pick the lane out of the read word and sign/zero-extend it.
  always_comb begin
    byte_lane = rd_word_q[{req_q.addr[1:0], 3'b000} +: 8];
    half_lane = rd_word_q[{req_q.addr[1], 4'b0000} +: 16];
    case (req_q.size)
      SIZE_BYTE: load_data = req_q.sign ? {{24{byte_lane[7]}}, byte_lane}
                                        : {24'h000000, byte_lane};
      SIZE_HALF: load_data = req_q.sign ? {{16{half_lane[15]}}, half_lane}
                                        : {16'h0000, half_lane};
      default:   load_data = rd_word_q;
    endcase
  end

  // Next-state logic: request capture, read capture and state sequencing.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rd_word_d = rd_word_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          req_d.write = bus.reqWrite;
          req_d.size  = bus.reqSize;
          req_d.sign  = bus.reqSigned;
          req_d.addr  = bus.reqAddress;
          req_d.data  = bus.reqData;
          req_d.err   = req_err;
          if (req_err)                                     state_d = RESP;
          else if (bus.reqWrite && bus.reqSize == SIZE_WORD) state_d = WRITE;
          else                                             state_d = READ;
        end
      end
      READ: begin
        rd_word_d = bus.memReadResult;
        state_d   = req_q.write ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    if (bus.respReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Outputs decode directly from the state register, so the asynchronous
  // reset pulls the write strobe low without waiting for a clock edge.
  assign bus.reqReady        = (state_q == IDLE);
  assign bus.respValid       = (state_q == RESP);
  assign bus.respError       = (state_q == RESP) && req_q.err;
  assign bus.respData        = ((state_q == RESP) && !req_q.err && !req_q.write)
                               ? load_data : 32'h0000_0000;
  assign bus.memAddress      = ((state_q == READ) || (state_q == WRITE))
                               ? {req_q.addr[31:2], 2'b00} : 32'h0000_0000;
  assign bus.memWriteEnabled = (state_q == WRITE);
  assign bus.memWriteInput   = (state_q == WRITE) ? merged_word : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural DataMemory
// (combinational read, write on the rising edge while memWriteEnabled is high).
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 1024;

  logic clock;
  logic reset;
  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_WORDS    (MEM_WORDS),
    .BASE_ADDRESS (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DataMemory model and write-pulse monitor.
  logic [31:0] mem [MEM_WORDS];
  int          wr_count;
  logic [31:0] last_wr_addr;

  assign bus.memReadResult = mem[bus.memAddress[11:2]];

  always @(posedge clock) begin
    if (bus.memWriteEnabled === 1'b1) begin
      mem[bus.memAddress[11:2]] <= bus.memWriteInput;
      wr_count     = wr_count + 1;
      last_wr_addr = bus.memAddress;
    end
  end

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: present at a falling edge, accept on the next rising
  // edge, wait for respValid (latency in cycles counted from the accept edge),
  // then complete the response immediately.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] dt,
                        output logic [31:0] rdata, output logic rerr, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.reqReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    bus.reqValid   = 1'b1;
    bus.reqWrite   = wr;
    bus.reqSize    = sz;
    bus.reqSigned  = sg;
    bus.reqAddress = ad;
    bus.reqData    = dt;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    lat = 1;
    while (!bus.respValid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("resp_timeout", 32'(bus.respValid), 32'd1);
    rdata = bus.respData;
    rerr  = bus.respError;
    @(negedge clock);
    bus.respReady = 1'b1;
    @(posedge clock); #1;
    bus.respReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          w0;

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    last_wr_addr = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
    reset          = 1'b1;
    bus.reqValid   = 1'b0;
    bus.reqWrite   = 1'b0;
    bus.reqSize    = 2'b00;
    bus.reqSigned  = 1'b0;
    bus.reqAddress = 32'h0;
    bus.reqData    = 32'h0;
    bus.respReady  = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_reqReady",  32'(bus.reqReady),        32'd1);
    check("rst_respValid", 32'(bus.respValid),       32'd0);
    check("rst_memWE",     32'(bus.memWriteEnabled), 32'd0);
    check("rst_memAddr",   bus.memAddress,           32'h0);
    check("rst_respData",  bus.respData,             32'h0);
    check("rst_respError", 32'(bus.respError),       32'd0);
    reset = 1'b0;

    // 1. Word store then word load
    w0 = wr_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hA5A5_A5A5, rd, er, lat);
    check("sw_pulses",  32'(wr_count - w0), 32'd1);
    check("sw_addr",    last_wr_addr,       32'h4);
    check("sw_latency", 32'(lat),           32'd2);
    check("sw_err",     32'(er),            32'd0);
    check("sw_data0",   rd,                 32'h0);
    check("sw_mem",     mem[1],             32'hA5A5_A5A5);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat);
    check("lw_data",    rd,        32'hA5A5_A5A5);
    check("lw_latency", 32'(lat),  32'd2);

    // 2. Byte store (read-modify-write) and byte loads
    w0 = wr_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00FF, rd, er, lat);
    check("sb_latency", 32'(lat),           32'd3);
    check("sb_pulses",  32'(wr_count - w0), 32'd1);
    check("sb_mem",     mem[1],             32'hA5A5_FFA5);
    do_req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, rd, er, lat);
    check("lb_signed",   rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, rd, er, lat);
    check("lb_unsigned", rd, 32'h0000_00FF);
    do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, rd, er, lat);
    check("lb_lane3",    rd, 32'hFFFF_FFA5);

    // 3. Halfword loads and store
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, rd, er, lat);
    check("lh_signed",   rd, 32'hFFFF_A5A5);
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, rd, er, lat);
    check("lh_unsigned", rd, 32'h0000_A5A5);
    do_req(1'b1, 2'b01, 1'b0, 32'h4, 32'h0000_1234, rd, er, lat);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_mem",     mem[1],   32'hA5A5_1234);
    do_req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, rd, er, lat);
    check("lb_lane0",   rd,       32'h0000_0034);

    // 4. Error cases: no memory cycle, memory untouched
    w0 = wr_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF, rd, er, lat);
    check("err_misal_flag", 32'(er),  32'd1);
    check("err_misal_data", rd,       32'h0);
    check("err_misal_lat",  32'(lat), 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h4, 32'hDEAD_BEEF, rd, er, lat);
    check("err_size_flag",  32'(er),  32'd1);
    check("err_size_data",  rd,       32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'(MEM_WORDS * 4), 32'hDEAD_BEEF, rd, er, lat);
    check("err_range_flag", 32'(er),  32'd1);
    do_req(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, rd, er, lat);
    check("err_lh_flag",    32'(er),  32'd1);
    check("err_lh_data",    rd,       32'h0);
    check("err_pulses",     32'(wr_count - w0), 32'd0);
    check("err_mem",        mem[1],   32'hA5A5_1234);
    do_req(1'b1, 2'b10, 1'b0, 32'(MEM_WORDS * 4 - 4), 32'h0BAD_CAFE, rd, er, lat);
    check("last_word_ok",   32'(er),  32'd0);
    check("last_word_mem",  mem[MEM_WORDS - 1], 32'h0BAD_CAFE);

    // 5. Response back-pressure; a request offered meanwhile is dropped
    w0 = wr_count;
    @(negedge clock);
    bus.reqValid   = 1'b1;
    bus.reqWrite   = 1'b0;
    bus.reqSize    = 2'b10;
    bus.reqSigned  = 1'b0;
    bus.reqAddress = 32'h4;
    bus.reqData    = 32'h0;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    @(posedge clock); #1;
    check("bp_valid0", 32'(bus.respValid), 32'd1);
    check("bp_data0",  bus.respData,       32'hA5A5_1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 0) begin
        bus.reqValid   = 1'b1;
        bus.reqWrite   = 1'b1;
        bus.reqSize    = 2'b10;
        bus.reqAddress = 32'h8;
        bus.reqData    = 32'h1111_1111;
      end
      @(posedge clock); #1;
      bus.reqValid = 1'b0;
      check("bp_valid", 32'(bus.respValid), 32'd1);
      check("bp_data",  bus.respData,       32'hA5A5_1234);
      check("bp_ready", 32'(bus.reqReady),  32'd0);
    end
    @(negedge clock);
    bus.respReady = 1'b1;
    @(posedge clock); #1;
    bus.respReady = 1'b0;
    check("bp_done_ready", 32'(bus.reqReady),  32'd1);
    check("bp_done_valid", 32'(bus.respValid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("bp_drop_pulses", 32'(wr_count - w0), 32'd0);
    check("bp_drop_mem",    mem[2],             32'h0);
    check("bp_idle",        32'(bus.reqReady),  32'd1);

    // 6. Reset during the WRITE cycle of a sub-word store
    w0 = wr_count;
    @(negedge clock);
    bus.reqValid   = 1'b1;
    bus.reqWrite   = 1'b1;
    bus.reqSize    = 2'b00;
    bus.reqSigned  = 1'b0;
    bus.reqAddress = 32'h4;
    bus.reqData    = 32'h0000_0077;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    @(posedge clock); #1;
    check("rw_we_before", 32'(bus.memWriteEnabled), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("rw_we_async",  32'(bus.memWriteEnabled), 32'd0);
    check("rw_ready_rst", 32'(bus.reqReady),        32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rw_ready",  32'(bus.reqReady),   32'd1);
    check("rw_valid",  32'(bus.respValid),  32'd0);
    check("rw_mem",    mem[1],              32'hA5A5_1234);
    check("rw_pulses", 32'(wr_count - w0),  32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rw_no_resp", 32'(bus.respValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
